sobol_gen: RTL and testbench

Parametrised multi-dimensional Sobol low-discrepancy sequence generator. It is the successor to the fixed 32-bit single-word generator. Each dimension holds a runtime-loadable direction-vector table and produces one WIDTH-bit point per accepted handshake, using the Gray-code recurrence x(i+1) = x(i) XOR V[d][lsz(i)]. It feeds the stochastic/quasi-Monte-Carlo datapath through a valid/ready stream, supports bounded or unbounded runs, and supports abort.

---
 rtl/sobol_pkg.sv | 20 ++
 rtl/sobol_gen_if.sv | 20 ++
 rtl/sobol_lsz.sv | 28 ++
 rtl/sobol_gen.sv | 138 +++++++++++++
 tb/tb_sobol_gen.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/sobol_pkg.sv
// Shared types and helpers for the Sobol sequence generator.
//   state_e    : controller states (idle / running / done pulse)
//   IDX_W      : index-bit width for the default 32-bit coordinate
//   dv_default : van der Corput direction vector V[k] = 1 << (width-1-k)
package sobol_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned IDX_W     = $clog2(DEF_WIDTH);

  // Wide enough for any practical coordinate width; callers truncate.
  localparam int unsigned DV_MAX_W  = 64;

  function automatic logic [DV_MAX_W-1:0] dv_default(input int unsigned k,
                                                     input int unsigned width);
    return {{(DV_MAX_W-1){1'b0}}, 1'b1} << (width - 1 - k);
  endfunction

endpackage

// File: rtl/sobol_gen_if.sv
// Output point stream of the Sobol generator.
//   out_valid : a point is presented
//   out_ready : consumer accepts the presented point
//   out_data  : coordinate d in bits [d*WIDTH +: WIDTH]
//   out_index : sequence index of the presented point
// master = generator side, slave = consumer side.
interface sobol_gen_if
  import sobol_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIMS  = 2
);
  logic                    out_valid;
  logic                    out_ready;
  logic [DIMS*WIDTH-1:0]   out_data;
  logic [WIDTH-1:0]        out_index;

  modport master (output out_valid, output out_data, output out_index, input out_ready);
  modport slave  (input out_valid, input out_data, input out_index, output out_ready);
endinterface

// File: rtl/sobol_lsz.sv
// Lowest-zero priority encoder.
//   idx_i      : index word
//   pos_o      : position of the lowest zero bit (0 when none)
//   all_ones_o : idx_i has no zero bit
module sobol_lsz
  import sobol_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] idx_i,
  output logic [IdxW-1:0]  pos_o,
  output logic             all_ones_o
);

  // Scan from MSB down so the lowest zero bit is the last one to win.
  always_comb begin
    pos_o      = '0;
    all_ones_o = 1'b1;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (!idx_i[i]) begin
        pos_o      = IdxW'(i);
        all_ones_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sobol_gen.sv
// Multi-dimensional Sobol low-discrepancy sequence generator.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start / stop        : begin a run (idle only) / abort a run (run only)
//   n_points            : points per run, latched at start; 0 = unbounded
//   dv_we/dim/idx/data  : direction-vector table write port (idle only)
//   out_if              : point stream (valid/ready, data, index)
//   busy                : high while running
//   done                : one-cycle pulse after the final point of a bounded run
// Each accepted point advances x ^= V[d][lsz(index)] in every dimension.
module sobol_gen
  import sobol_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIMS  = 2,
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int unsigned DimW = (DIMS > 1) ? $clog2(DIMS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] n_points,
  input  logic             dv_we,
  input  logic [DimW-1:0]  dv_dim,
  input  logic [IdxW-1:0]  dv_idx,
  input  logic [WIDTH-1:0] dv_data,
  sobol_gen_if.master      out_if,
  output logic             busy,
  output logic             done
);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      dv_q [DIMS][WIDTH];
  logic [WIDTH-1:0]      dv_d [DIMS][WIDTH];
  logic [DIMS*WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0]      index_q, index_d;
  logic [WIDTH-1:0]      npts_q, npts_d;
  logic                  valid_q, valid_d;

  logic [IdxW-1:0]       lsz_pos;
  logic                  lsz_all_ones;
  logic                  hs;
  logic                  last;

  sobol_lsz #(
    .WIDTH (WIDTH)
  ) u_lsz (
    .idx_i      (index_q),
    .pos_o      (lsz_pos),
    .all_ones_o (lsz_all_ones)
  );

  assign hs   = valid_q & out_if.out_ready;
  assign last = (npts_q != '0) && (index_q == npts_q - WIDTH'(1));

  always_comb begin
    state_d = state_q;
    dv_d    = dv_q;
    data_d  = data_q;
    index_d = index_q;
    npts_d  = npts_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (dv_we) begin
          for (int d = 0; d < int'(DIMS); d++) begin
            if (dv_dim == DimW'(d)) dv_d[d][dv_idx] = dv_data;
          end
        end
        if (start) begin
          state_d = StRun;
          data_d  = '0;
          index_d = '0;
          valid_d = 1'b1;
          npts_d  = n_points;
        end
      end
      StRun: begin
        if (hs) begin
          // An all-ones index has no zero bit: the sequence restarts from 0.
          if (lsz_all_ones) begin
            data_d  = '0;
            index_d = '0;
          end else begin
            for (int d = 0; d < int'(DIMS); d++) begin
              data_d[d*WIDTH +: WIDTH] = data_q[d*WIDTH +: WIDTH] ^ dv_q[d][lsz_pos];
            end
            index_d = index_q + WIDTH'(1);
          end
          if (last) begin
            state_d = StDone;
            valid_d = 1'b0;
          end
        end
        // Abort wins over completion; a same-cycle transfer still counts.
        if (stop) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      index_q <= '0;
      npts_q  <= '0;
      valid_q <= 1'b0;
      for (int unsigned d = 0; d < DIMS; d++) begin
        for (int unsigned k = 0; k < WIDTH; k++) begin
          dv_q[d][k] <= WIDTH'(dv_default(k, WIDTH));
        end
      end
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      index_q <= index_d;
      npts_q  <= npts_d;
      valid_q <= valid_d;
      dv_q    <= dv_d;
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_index = index_q;
  assign busy             = (state_q == StRun);
  assign done             = (state_q == StDone);

endmodule

// File: tb/tb_sobol_gen.sv
// Directed bench for sobol_gen: a 32-bit two-dimension instance and a 4-bit
// single-dimension instance for the index wrap.
module tb_sobol_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int hs_base  = 0;

  // 32-bit, 2-dimension instance
  logic        start, stop, dv_we, dv_dim, busy, done;
  logic [31:0] n_points, dv_data;
  logic [4:0]  dv_idx;
  sobol_gen_if #(.WIDTH(32), .DIMS(2)) s_if ();

  sobol_gen #(.WIDTH(32), .DIMS(2)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .n_points (n_points),
    .dv_we    (dv_we),
    .dv_dim   (dv_dim),
    .dv_idx   (dv_idx),
    .dv_data  (dv_data),
    .out_if   (s_if.master),
    .busy     (busy),
    .done     (done)
  );

  // 4-bit, 1-dimension instance
  logic       start4, stop4, dv_we4, dv_dim4, busy4, done4;
  logic [3:0] n4, dv_data4;
  logic [1:0] dv_idx4;
  sobol_gen_if #(.WIDTH(4), .DIMS(1)) s4_if ();

  sobol_gen #(.WIDTH(4), .DIMS(1)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start4),
    .stop     (stop4),
    .n_points (n4),
    .dv_we    (dv_we4),
    .dv_dim   (dv_dim4),
    .dv_idx   (dv_idx4),
    .dv_data  (dv_data4),
    .out_if   (s4_if.master),
    .busy     (busy4),
    .done     (done4)
  );

  always @(posedge clk) begin
    if (s_if.out_valid && s_if.out_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pt(input string tag, input int idx, input logic [31:0] d1,
                        input logic [31:0] d0);
    chk($sformatf("%s_valid_%0d", tag, idx), {63'd0, s_if.out_valid}, 64'd1);
    chk($sformatf("%s_index_%0d", tag, idx), {32'd0, s_if.out_index}, 64'(idx));
    chk($sformatf("%s_data_%0d", tag, idx), s_if.out_data, {d1, d0});
  endtask

  // Hand-derived expected points
  logic [31:0] vdc [8];
  logic [31:0] cus [6];

  initial begin
    vdc = '{32'h0, 32'h80000000, 32'hC0000000, 32'h40000000,
            32'h60000000, 32'hE0000000, 32'hA0000000, 32'h20000000};
    cus = '{32'h0, 32'h80000000, 32'h40000000, 32'hC0000000,
            32'h60000000, 32'hE0000000};

    start = 0; stop = 0; dv_we = 0; dv_dim = 0; dv_idx = 0; dv_data = 0; n_points = 0;
    s_if.out_ready = 0;
    start4 = 0; stop4 = 0; dv_we4 = 0; dv_dim4 = 0; dv_idx4 = 0; dv_data4 = 0; n4 = 0;
    s4_if.out_ready = 0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", {63'd0, s_if.out_valid}, 64'd0);
    chk("rst_data", s_if.out_data, 64'd0);
    chk("rst_index", {32'd0, s_if.out_index}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    rst_n = 1;

    // Bounded run of 8 with default tables
    @(negedge clk);
    start = 1; n_points = 32'd8; s_if.out_ready = 1;
    @(negedge clk);
    start = 0; hs_base = hs_cnt;
    for (int i = 0; i < 8; i++) begin
      chk_pt("t1", i, vdc[i], vdc[i]);
      chk($sformatf("t1_busy_%0d", i), {63'd0, busy}, 64'd1);
      chk($sformatf("t1_done_%0d", i), {63'd0, done}, 64'd0);
      @(negedge clk);
    end
    chk("t1_done_pulse", {63'd0, done}, 64'd1);
    chk("t1_busy_in_done", {63'd0, busy}, 64'd0);
    chk("t1_valid_in_done", {63'd0, s_if.out_valid}, 64'd0);
    chk("t1_handshakes", 64'(hs_cnt - hs_base), 64'd8);
    @(negedge clk);
    chk("t1_done_cleared", {63'd0, done}, 64'd0);

    // Load dim1 V[0..2]; last write coincides with start
    dv_we = 1; dv_dim = 1; dv_idx = 0; dv_data = 32'h80000000;
    @(negedge clk);
    dv_idx = 1; dv_data = 32'hC0000000;
    @(negedge clk);
    dv_idx = 2; dv_data = 32'hA0000000; start = 1; n_points = 32'd0;
    @(negedge clk);
    dv_we = 0; start = 0; hs_base = hs_cnt;
    for (int i = 0; i < 6; i++) begin
      chk_pt("t2", i, cus[i], vdc[i]);
      if (i == 2) begin
        s_if.out_ready = 0;
        repeat (3) begin
          @(negedge clk);
          chk_pt("t2_hold", 2, cus[2], vdc[2]);
        end
        s_if.out_ready = 1;
      end
      if (i == 5) stop = 1;
      @(negedge clk);
    end
    stop = 0;
    chk("t2_stop_valid", {63'd0, s_if.out_valid}, 64'd0);
    chk("t2_stop_busy", {63'd0, busy}, 64'd0);
    chk("t2_stop_done", {63'd0, done}, 64'd0);
    chk("t2_handshakes", 64'(hs_cnt - hs_base), 64'd6);
    @(negedge clk);
    chk("t2_stop_no_done", {63'd0, done}, 64'd0);

    // Restart; table write during the run must be ignored
    start = 1; n_points = 32'd4;
    @(negedge clk);
    start = 0;
    chk_pt("t3", 0, 32'h0, 32'h0);
    dv_we = 1; dv_dim = 0; dv_idx = 0; dv_data = 32'hFFFFFFFF;
    @(negedge clk);
    dv_we = 0;
    chk_pt("t3", 1, cus[1], vdc[1]);
    @(negedge clk);
    chk_pt("t3", 2, cus[2], vdc[2]);

    // Asynchronous reset mid-run
    rst_n = 0;
    #1;
    chk("mrst_valid", {63'd0, s_if.out_valid}, 64'd0);
    chk("mrst_data", s_if.out_data, 64'd0);
    chk("mrst_index", {32'd0, s_if.out_index}, 64'd0);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst_n = 1;

    // Table back to van der Corput in both dimensions
    @(negedge clk);
    start = 1; n_points = 32'd3;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 3; i++) begin
      chk_pt("t4", i, vdc[i], vdc[i]);
      @(negedge clk);
    end
    chk("t4_done", {63'd0, done}, 64'd1);

    // 4-bit unbounded run wraps after index 15
    start4 = 1; n4 = 4'd0; s4_if.out_ready = 1;
    @(negedge clk);
    start4 = 0;
    chk("w4_index_0", {60'd0, s4_if.out_index}, 64'd0);
    chk("w4_data_0", {60'd0, s4_if.out_data}, 64'd0);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      if (i == 4) chk("w4_data_4", {60'd0, s4_if.out_data}, 64'h6);
    end
    chk("w4_index_15", {60'd0, s4_if.out_index}, 64'd15);
    chk("w4_data_15", {60'd0, s4_if.out_data}, 64'h1);
    @(negedge clk);
    chk("w4_wrap_index", {60'd0, s4_if.out_index}, 64'd0);
    chk("w4_wrap_data", {60'd0, s4_if.out_data}, 64'd0);
    chk("w4_wrap_busy", {63'd0, busy4}, 64'd1);
    chk("w4_wrap_valid", {63'd0, s4_if.out_valid}, 64'd1);
    @(negedge clk);
    chk("w4_rep_index", {60'd0, s4_if.out_index}, 64'd1);
    chk("w4_rep_data", {60'd0, s4_if.out_data}, 64'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
